// File: rtl/vga_pixel_out_if.sv
// Scan-position / tile-fetch inputs and sync/colour/tick outputs of the VGA output stage.
interface vga_pixel_out_if;
   localparam int unsigned POS_W  = 10;
   localparam int unsigned TILE_W = 4;
   localparam int unsigned CH_W   = 4;

   logic [POS_W-1:0]  row;
   logic [POS_W-1:0]  col;
   logic              re;
   logic [TILE_W-1:0] rdata;
   logic              hsync;
   logic              vsync;
   logic [CH_W-1:0]   red;
   logic [CH_W-1:0]   green;
   logic [CH_W-1:0]   blue;
   logic              frame_tick;

   modport master (
      output row, col, re, rdata,
      input  hsync, vsync, red, green, blue, frame_tick
   );

   modport slave (
      input  row, col, re, rdata,
      output hsync, vsync, red, green, blue, frame_tick
   );
endinterface

// File: rtl/vga_pixel_out.sv
// VGA output stage: 2-cycle pipeline from scan position to registered sync and RGB,
// with tile-to-colour palette, blanking, food blink and a once-per-frame tick.
module vga_pixel_out #(
   parameter int unsigned H_VISIBLE    = 640,
   parameter int unsigned V_VISIBLE    = 480,
   parameter int unsigned HSYNC_START  = 656,
   parameter int unsigned HSYNC_END    = 751,
   parameter int unsigned VSYNC_START  = 490,
   parameter int unsigned VSYNC_END    = 491,
   parameter int unsigned BLINK_FRAMES = 15
) (
   input  logic           clk,
   input  logic           reset,
   vga_pixel_out_if.slave bus
);
   localparam int unsigned POS_W  = 10;
   localparam int unsigned TILE_W = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned CH_W   = 4;
   localparam int unsigned RGB_W  = 3 * CH_W;

   localparam logic [POS_W-1:0] LP_H_VIS    = POS_W'(H_VISIBLE);
   localparam logic [POS_W-1:0] LP_V_VIS    = POS_W'(V_VISIBLE);
   localparam logic [POS_W-1:0] LP_HS_START = POS_W'(HSYNC_START);
   localparam logic [POS_W-1:0] LP_HS_END   = POS_W'(HSYNC_END);
   localparam logic [POS_W-1:0] LP_VS_START = POS_W'(VSYNC_START);
   localparam logic [POS_W-1:0] LP_VS_END   = POS_W'(VSYNC_END);
   localparam logic [CNT_W-1:0] LP_BLINK_LAST = CNT_W'(BLINK_FRAMES);

   logic              r_vis_d;
   logic              r_hs_d;
   logic              r_vs_d;
   logic              r_re_d;
   logic              r_frame_tick;
   logic [TILE_W-1:0] r_tile_hold;
   logic [CNT_W-1:0]  r_blink_cnt;
   logic              r_blink_on;
   logic              r_hsync;
   logic              r_vsync;
   logic [RGB_W-1:0]  r_rgb;

   logic [TILE_W-1:0] w_tile_cur;
   logic [RGB_W-1:0]  w_rgb;

   // Tile code to {R,G,B}; food goes dark during the off half of the blink.
   function automatic logic [RGB_W-1:0] f_palette(input logic [TILE_W-1:0] tile,
                                                  input logic              blink_on);
      logic [RGB_W-1:0] rgb;
      case (tile)
         4'd0:    rgb = 12'h000;
         4'd1:    rgb = 12'h0F0;
         4'd2:    rgb = 12'h0F8;
         4'd3:    rgb = blink_on ? 12'hF00 : 12'h000;
         4'd4:    rgb = 12'h888;
         default: rgb = 12'hF0F;
      endcase
      return rgb;
   endfunction

   // Stage 1: position decode and registered frame tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vis_d      <= 1'b0;
         r_hs_d       <= 1'b0;
         r_vs_d       <= 1'b0;
         r_re_d       <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_vis_d      <= (bus.row < LP_H_VIS) && (bus.col < LP_V_VIS);
         r_hs_d       <= (bus.row >= LP_HS_START) && (bus.row <= LP_HS_END);
         r_vs_d       <= (bus.col >= LP_VS_START) && (bus.col <= LP_VS_END);
         r_re_d       <= bus.re;
         r_frame_tick <= (bus.row == '0) && (bus.col == LP_V_VIS);
      end
   end

   // rdata is only meaningful the cycle after a fetch; otherwise repeat the last tile.
   always_comb begin
      w_tile_cur = r_re_d ? bus.rdata : r_tile_hold;
      w_rgb      = r_vis_d ? f_palette(w_tile_cur, r_blink_on) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tile_hold <= '0;
      end else begin
         r_tile_hold <= w_tile_cur;
      end
   end

   // Frame counter for food blink; toggle and clear share the wrap edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_frame_tick) begin
         if (r_blink_cnt == LP_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
         end
      end
   end

   // Stage 2: output registers, sync active low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_rgb   <= '0;
      end else begin
         r_hsync <= ~r_hs_d;
         r_vsync <= ~r_vs_d;
         r_rgb   <= w_rgb;
      end
   end

   assign bus.hsync      = r_hsync;
   assign bus.vsync      = r_vsync;
   assign bus.red        = r_rgb[RGB_W-1 -: CH_W];
   assign bus.green      = r_rgb[2*CH_W-1 -: CH_W];
   assign bus.blue       = r_rgb[CH_W-1 -: CH_W];
   assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: directed scans plus random positions, checked against a
// cycle-indexed reference model of the visible, sync, palette and blink rules.
module tb_vga_pixel_out;
   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   vga_pixel_out_if bus();

   vga_pixel_out dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
      logic re;
      logic tick;
   } cyc_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   cyc_t       prev;
   logic [3:0] last_tile;
   int         ticks;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] rgb();
      return {bus.red, bus.green, bus.blue};
   endfunction

   function automatic logic [11:0] ref_color(input logic [3:0] t, input bit blink_on);
      if (t == 4'd0) return 12'h000;
      if (t == 4'd1) return 12'h0F0;
      if (t == 4'd2) return 12'h0F8;
      if (t == 4'd3) return blink_on ? 12'hF00 : 12'h000;
      if (t == 4'd4) return 12'h888;
      return 12'hF0F;
   endfunction

   function automatic cyc_t classify(input int r, input int c, input bit re_i);
      cyc_t x;
      x.vis  = (r < 640) && (c < 480);
      x.hs   = (r >= 656) && (r <= 751);
      x.vs   = (c >= 490) && (c <= 491);
      x.re   = re_i;
      x.tick = (r == 0) && (c == 480);
      return x;
   endfunction

   task automatic model_reset();
      prev      = '0;
      last_tile = 4'd0;
      ticks     = 0;
   endtask

   // One pixel clock: present inputs, then check the previous cycle's pixel and this cycle's tick.
   task automatic step(input int r, input int c, input bit re_i, input int rd);
      cyc_t       cur;
      logic [3:0] tile;
      logic [11:0] col_e;
      bus.row   = 10'(r);
      bus.col   = 10'(c);
      bus.re    = re_i;
      bus.rdata = 4'(rd);
      cur = classify(r, c, re_i);
      @(posedge clk);
      #1;
      tile      = prev.re ? 4'(rd) : last_tile;
      last_tile = tile;
      col_e     = prev.vis ? ref_color(tile, ((ticks / 16) % 2) == 0) : 12'h000;
      chk("pixel", 32'({bus.hsync, bus.vsync, rgb()}), 32'({~prev.hs, ~prev.vs, col_e}));
      chk("frame_tick", 32'(bus.frame_tick), 32'(cur.tick));
      ticks += int'(prev.tick);
      prev = cur;
   endtask

   task automatic reset_pulse();
      #2 reset = 1'b0;
      #1;
      chk("rst_async", 32'({bus.hsync, bus.vsync, rgb(), bus.frame_tick}), 32'({2'b11, 12'h000, 1'b0}));
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold", 32'({bus.hsync, bus.vsync, rgb(), bus.frame_tick}), 32'({2'b11, 12'h000, 1'b0}));
      #2 reset = 1'b1;
      model_reset();
   endtask

   initial begin
      int hl, nz, first_low, vl, tk, h8;
      bus.row = 10'd0; bus.col = 10'd0; bus.re = 1'b0; bus.rdata = 4'd0;
      #1 reset = 1'b0;
      #1;
      chk("rst_init", 32'({bus.hsync, bus.vsync, rgb(), bus.frame_tick}), 32'({2'b11, 12'h000, 1'b0}));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();

      // Palette and latency
      step(0, 0, 1, 0);   step(1, 0, 0, 3);  chk("pal_food", 32'(rgb()), 32'h0F00);
      step(0, 0, 1, 0);   step(1, 0, 0, 1);  chk("pal_body", 32'(rgb()), 32'h00F0);
      step(0, 0, 1, 0);   step(1, 0, 0, 9);  chk("pal_err",  32'(rgb()), 32'h0F0F);
      step(640, 0, 1, 0); step(641, 0, 0, 1); chk("pal_blank", 32'(rgb()), 32'h0000);

      // Full line at col=10 with a body tile fetched every cycle
      hl = 0; nz = 0; first_low = -1;
      for (int i = 0; i < 802; i++) begin
         step((i < 800) ? i : 800, 10, 1'b1, 1);
         if (!bus.hsync) begin
            hl++;
            if (first_low < 0) first_low = i;
         end
         if (rgb() != 12'h000) nz++;
      end
      chk("hsync_len", 32'(hl), 32'd96);
      chk("hsync_first", 32'(first_low), 32'd657);
      chk("rgb_visible", 32'(nz), 32'd640);

      // Column sweep at row 0: vsync lines and one frame tick
      vl = 0; tk = 0;
      for (int c = 0; c < 527; c++) begin
         step(0, (c < 525) ? c : 600, 1'b0, int'($urandom_range(0, 15)));
         if (!bus.vsync) vl++;
         if (bus.frame_tick) tk++;
      end
      chk("vsync_len", 32'(vl), 32'd2);
      chk("tick_count", 32'(tk), 32'd1);

      // Hold last tile while re is low
      h8 = 0;
      step(10, 20, 1, 0);
      step(11, 20, 0, 4);
      if (rgb() == 12'h888) h8++;
      for (int k = 0; k < 19; k++) begin
         step(12 + k, 20, 1'b0, int'($urandom_range(0, 15)));
         if (rgb() == 12'h888) h8++;
      end
      chk("hold_wall", 32'(h8), 32'd20);

      // Mid-line reset with hsync low, then blink over 33 frame ticks
      step(700, 10, 0, 0);
      step(701, 10, 0, 0);
      reset_pulse();
      for (int n = 0; n < 34; n++) begin
         step(5, 5, 1, 0);
         step(6, 5, 0, 3);
         chk("blink", 32'(rgb()), (((n / 16) % 2) == 0) ? 32'h0F00 : 32'h0000);
         step(0, 480, 0, 0);
      end

      // Random positions, fetches and ticks, with one reset in the middle
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) reset_pulse();
         if ($urandom_range(0, 7) == 0)
            step(0, 480, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         else
            step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 600)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
